// File: rtl/prio_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the
// sequenced 4-to-16 strobe decoder.
package prio_pkg;

  localparam int ADDR_W   = 4;
  localparam int ONEHOT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ADDR_W-1:0] idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/onehot_strobe_decoder_4to16.sv
// Buffers 4-bit addresses and replays each as a timed one-hot strobe on
// {out_a, out_b}, with a guaranteed all-zero cycle between strobes.
module onehot_strobe_decoder_4to16
  import prio_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADDR_W-1:0]               address,
  output logic [7:0]                      out_a,
  output logic [7:0]                      out_b,
  output logic                            done,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending
);

  localparam int HOLD_W = 8;

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [ONEHOT_W-1:0]   strobe_q, strobe_d;
  logic                  done_q, done_d;
  logic                  head_seen_q;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]     fifo_head;

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .wdata_i (address),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending)
  );

  assign in_ready = !fifo_full;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);
  assign out_a    = strobe_q[15:8];
  assign out_b    = strobe_q[7:0];
  assign done     = done_q;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    strobe_d = strobe_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_PULSE: begin
        if (hold_q == '0) begin
          state_d  = ST_GAP;
          strobe_d = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          done_d = (hold_q == HOLD_W'(1));
        end
      end
      ST_GAP: begin
        state_d  = ST_IDLE;
        strobe_d = '0;
      end
      default: begin
        // The unused encoding behaves as IDLE. An entry must sit in the
        // FIFO for a full cycle before it may be popped.
        state_d  = ST_IDLE;
        strobe_d = '0;
        if (!fifo_empty && head_seen_q) begin
          fifo_pop = 1'b1;
          strobe_d = onehot(fifo_head);
          hold_d   = HOLD_W'(PULSE_CYCLES - 1);
          done_d   = (PULSE_CYCLES == 1);
          state_d  = ST_PULSE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      strobe_q    <= '0;
      done_q      <= 1'b0;
      head_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      head_seen_q <= !fifo_empty;
    end
  end

endmodule

// File: tb/tb_onehot_strobe_decoder_4to16.sv
// Directed bench: per-cycle vector table, then hand-written sequences for
// ordering, back-pressure, mid-strobe reset and a PULSE_CYCLES=1 build.
module tb_onehot_strobe_decoder_4to16;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready;
  logic [3:0] address;
  logic [7:0] out_a, out_b;
  logic       done, busy;
  logic [1:0] pending;

  logic       rst_n1, in_valid1, in_ready1;
  logic [3:0] address1;
  logic [7:0] out_a1, out_b1;
  logic       done1, busy1;
  logic [1:0] pending1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  onehot_strobe_decoder_4to16 #(.PULSE_CYCLES(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .out_a(out_a), .out_b(out_b), .done(done),
    .busy(busy), .pending(pending)
  );

  onehot_strobe_decoder_4to16 #(.PULSE_CYCLES(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .address(address1), .out_a(out_a1), .out_b(out_b1), .done(done1),
    .busy(busy1), .pending(pending1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       in_valid;
    logic [3:0] addr;
    logic [7:0] a;
    logic [7:0] b;
    logic       done;
    logic       busy;
    logic [1:0] pend;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [3:0] ad,
                     input logic [7:0] a, input logic [7:0] b, input logic d,
                     input logic bz, input logic [1:0] p, input logic rd);
    vec_t t;
    t = '{r, v, ad, a, b, d, bz, p, rd};
    vecs.push_back(t);
  endtask

  // Strobe monitor for the PULSE_CYCLES=4 instance.
  typedef struct {
    logic [15:0] val;
    int          len;
    int          dones;
    bit          last_done;
    bit          no_gap;
  } strobe_t;

  strobe_t     strobes[$];
  strobe_t     cur;
  logic [15:0] prev_v;
  logic [15:0] now_v;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    now_v = {out_a, out_b};
    if (mon_en) begin
      if (now_v != 16'h0) begin
        if (prev_v == 16'h0 || now_v != prev_v) begin
          if (prev_v != 16'h0) strobes.push_back(cur);
          cur.val       = now_v;
          cur.len       = 1;
          cur.dones     = int'(done);
          cur.last_done = done;
          cur.no_gap    = (prev_v != 16'h0);
        end else begin
          cur.len++;
          cur.dones += int'(done);
          cur.last_done = done;
        end
      end else if (prev_v != 16'h0) begin
        strobes.push_back(cur);
      end
      prev_v = now_v;
    end else begin
      prev_v = 16'h0;
    end
  end

  task automatic send(input logic [3:0] ad);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    address  = ad;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk);
    end
    check("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic wait_idle();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_strobes(input string name, input logic [15:0] vals[$], input int len);
    check({name, "_count"}, strobes.size(), vals.size());
    foreach (vals[i]) begin
      if (i < strobes.size()) begin
        check({name, "_strobe"},
              {strobes[i].val, strobes[i].len[7:0], 3'b0, strobes[i].no_gap,
               3'b0, strobes[i].last_done},
              {vals[i], len[7:0], 3'b0, 1'b0, 3'b0, 1'b1});
        check({name, "_dones"}, strobes[i].dones, 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_vals[$];
    int          acc_idx[$];
    int          exp_acc[5];
    int          pmax;
    bit          saw_low, acc;

    rst_n = 1'b0; in_valid = 1'b0; address = 4'h0;
    rst_n1 = 1'b0; in_valid1 = 1'b0; address1 = 4'h0;

    // Reset (transfer offered during reset discarded), single 0xA strobe,
    // then two identical 0x5 strobes separated by a zero gap.
    add(0, 1, 4'hA, 8'h00, 8'h00, 0, 0, 2'd0, 1);
    add(1, 1, 4'hA, 8'h00, 8'h00, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h04, 8'h00, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h04, 8'h00, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h04, 8'h00, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h04, 8'h00, 1, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 0, 2'd0, 1);
    add(1, 1, 4'h5, 8'h00, 8'h00, 0, 1, 2'd1, 1);
    add(1, 1, 4'h5, 8'h00, 8'h00, 0, 1, 2'd2, 0);
    add(1, 0, 4'h0, 8'h00, 8'h20, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 1, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 1, 2'd1, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h20, 1, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 1, 2'd0, 1);
    add(1, 0, 4'h0, 8'h00, 8'h00, 0, 0, 2'd0, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_n    = vecs[i].rst_n;
      rst_n1   = vecs[i].rst_n;
      in_valid = vecs[i].in_valid;
      address  = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {11'b0, out_a, out_b, done, busy, pending, in_ready},
            {11'b0, vecs[i].a, vecs[i].b, vecs[i].done, vecs[i].busy,
             vecs[i].pend, vecs[i].rdy});
    end

    // Back-to-back 0, 7, 8, 15: strict order, 4-cycle strobes, zero gaps.
    strobes.delete();
    mon_en = 1'b1;
    send(4'h0); send(4'h7); send(4'h8); send(4'hF);
    wait_idle();
    exp_vals = '{16'h0001, 16'h0080, 16'h0100, 16'h8000};
    check_strobes("b2b", exp_vals, 4);

    // in_valid held 20 cycles with 0x3: FIFO saturates, accepts every 6 cycles.
    strobes.delete();
    pmax = 0; saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      address  = 4'h3;
      acc      = in_ready;
      if (int'(pending) > pmax) pmax = int'(pending);
      if (!in_ready) saw_low = 1'b1;
      @(posedge clk);
      if (acc) acc_idx.push_back(i);
      @(negedge clk);
    end
    wait_idle();
    check("sat_pending_max", pmax, 32'd2);
    check("sat_ready_low", {31'b0, saw_low}, 32'd1);
    exp_acc = '{0, 1, 3, 9, 15};
    check("sat_accept_count", acc_idx.size(), 32'd5);
    foreach (exp_acc[i])
      if (i < acc_idx.size()) check($sformatf("sat_accept%0d", i), acc_idx[i], exp_acc[i]);
    exp_vals = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0008};
    check_strobes("sat", exp_vals, 4);

    // Reset in the 2nd held cycle of a 0xC strobe with 0x9 queued.
    strobes.delete();
    send(4'hC);
    send(4'h9);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_held1", {24'b0, out_a}, 32'h10);
    @(negedge clk);
    check("rst_held2", {24'b0, out_a}, 32'h10);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    address  = 4'h9;
    @(negedge clk);
    check("rst_state", {11'b0, out_a, out_b, done, busy, pending, in_ready},
          {11'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1});
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_replay_busy", {31'b0, busy}, 32'd0);
    check("rst_strobe_count", strobes.size(), 32'd1);
    if (strobes.size() > 0)
      check("rst_truncated", {strobes[0].val, strobes[0].len[15:0]}, {16'h1000, 16'd2});
    mon_en = 1'b0;

    // PULSE_CYCLES=1 instance, address 0x1.
    @(negedge clk);
    in_valid1 = 1'b1;
    address1  = 4'h1;
    check("p1_ready", {31'b0, in_ready1}, 32'd1);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("p1_queued", {14'b0, out_a1, out_b1, pending1}, {14'b0, 16'h0, 2'd1});
    @(negedge clk);
    check("p1_resident", {15'b0, out_a1, out_b1, done1}, {15'b0, 16'h0, 1'b0});
    @(negedge clk);
    check("p1_strobe", {15'b0, out_a1, out_b1, done1}, {15'b0, 16'h0002, 1'b1});
    @(negedge clk);
    check("p1_gap", {14'b0, out_a1, out_b1, done1, busy1}, {14'b0, 16'h0, 1'b0, 1'b1});
    @(negedge clk);
    check("p1_idle", {31'b0, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_decoder_4to16.md
# onehot_strobe_decoder_4to16

Sequenced 4-to-16 decoder. It is the counterpart of the 16-input priority encoder: it takes encoded 4-bit addresses over a valid/ready handshake and buffers them in a small FIFO. It then replays each one as a timed one-hot strobe on two 8-bit buses, `out_a` (bits 15:8) and `out_b` (bits 7:0). A guaranteed all-zero gap separates consecutive strobes, so back-to-back identical addresses stay distinguishable downstream.

## Interface
- `PULSE_CYCLES`, default 4: cycles each one-hot strobe is held. Legal range 1..255.
- `FIFO_DEPTH`, default 2: input buffer entries. Must be a power of 2, at least 2.
- `clk` input, 1: the single clock. All state updates on its rising edge.
- `rst_n` input, 1: synchronous, active-low reset.
- `in_valid` input, 1: `address` is valid this cycle.
- `in_ready` output, 1: block can accept an address this cycle.
- `address` input, 4: encoded index 0..15. Index k selects bit k of {`out_a`, `out_b`}.
- `out_a` output, 8: one-hot strobe, upper half (bits 15:8). Registered.
- `out_b` output, 8: one-hot strobe, lower half (bits 7:0). Registered.
- `done` output, 1: single-cycle pulse in the last held cycle of each strobe. Registered.
- `busy` output, 1: FIFO non-empty or FSM not in IDLE.
- `pending` output, $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- Handshake: a transfer occurs at a rising edge where `in_valid` and `in_ready` are both 1. `in_ready` = (occupancy < FIFO_DEPTH), taken from registered occupancy only, with no combinational path from `in_valid`.
- `address` is written to the FIFO tail on transfer. `in_valid` while `in_ready`=0 is ignored; the sender must hold the address.
- FSM states are IDLE, PULSE and GAP.
  - IDLE, FIFO non-empty: pop the head, load one-hot(head) into {`out_a`,`out_b`}, load hold counter with PULSE_CYCLES-1, go to PULSE.
  - PULSE: hold the outputs. If counter = 0, assert `done` this cycle, clear outputs at the next edge and go to GAP. Otherwise decrement.
  - GAP: outputs zero for exactly one cycle, then IDLE.
- Outputs are exactly one-hot in PULSE and all-zero in every other state.
- Push and pop in the same edge: both take effect, so occupancy is unchanged. The FIFO read and write pointers wrap modulo FIFO_DEPTH.
- No bypass: a newly written entry is never popped in its write cycle.
- Reset (`rst_n`=0 at an edge) forces the following, regardless of state, including mid-strobe:
  - FSM to IDLE, with the FIFO flushed (pointers and occupancy 0).
  - `out_a`=`out_b`=0x00 and `done`=0.
  - Consequently `busy`=0, `pending`=0 and `in_ready`=1 after that edge.
  - A transfer offered in the reset cycle is discarded.

## Timing
- Latency: a transfer at edge E0 into an empty, IDLE block gives a non-zero output from edge E0+2 (one cycle of FIFO residency, then the pop/load edge).
- The strobe is held from edge E0+2 until edge E0+2+PULSE_CYCLES. `done` is high in the final held cycle.
- The GAP lasts one cycle. The next pop happens at the IDLE edge after GAP.
- Steady-state throughput is one strobe per PULSE_CYCLES+2 cycles: the PULSE cycles, one GAP cycle and one IDLE/pop cycle.
- When PULSE_CYCLES=1, `done` coincides with the first and only held cycle.
- Full FIFO: `in_ready` falls at the edge occupancy reaches FIFO_DEPTH. It rises the cycle after a pop.

## Structure
- Shared package/header `prio_pkg` holds:
  - `ADDR_W`=4 and `ONEHOT_W`=16.
  - FSM state encodings `ST_IDLE`=2'd0, `ST_PULSE`=2'd1, `ST_GAP`=2'd2. The value 2'd3 is unreachable and decodes to IDLE.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH) holds the sync reset, push/pop, full/empty and count logic. The top level holds the FSM, hold counter and output registers.
- One-hot decode: `1 << head`, computed combinationally and registered on load only.

## Test plan
- Reset then a single transfer of address 0xA at E0 (PULSE_CYCLES=4) -> `out_a`=0x04 and `out_b`=0x00 during E0+2..E0+5; `done` high in the E0+5 cycle; zeros at E0+6; `busy` falls after GAP.
- Addresses 0, 7, 8, 15 sent back-to-back -> `out_b`=0x01, then `out_b`=0x80, then `out_a`=0x01, then `out_a`=0x80, each held 4 cycles with one zero gap between strobes and strictly in order.
- `in_valid` held high with address 0x3 for 20 cycles, FIFO_DEPTH=2 -> `pending` saturates at 2 and `in_ready` drops. Acceptances are spaced 6 cycles in steady state, and no strobe is lost or duplicated.
- Same address 0x5 twice -> `out_b`=0x20 for 4 cycles, 0x00 for at least 1 cycle, then `out_b`=0x20 for another 4 cycles; `done` pulses twice.
- `rst_n` low in the 2nd held cycle of an address 0xC strobe with 1 entry queued -> next edge: outputs 0x00/0x00, `pending`=0, `busy`=0, `in_ready`=1; no strobe for the queued entry ever appears.
- PULSE_CYCLES=1 build, address 0x1 -> `out_b`=0x02 for exactly 1 cycle with `done` high that same cycle.
